snn_input_ctrl: RTL and testbench

- Sequences one inference of the SNN.
- Collects a 784-pixel binary image from the UART receiver as 98 bytes and unpacks each byte into eight 1-bit writes to the input-unit RAM.
- Then starts the SNN core and shares the input RAM address port with it while it runs.
- Captures the classified digit and hands it to the UART transmitter.

---
 rtl/snn_input_ctrl_if.sv | 34 +++
 rtl/snn_input_ctrl.sv | 136 +++++++++++++
 tb/tb_snn_input_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/snn_input_ctrl_if.sv
// Bundles the UART, input-RAM, SNN-core and transmit-side signals of the inference sequencer.
// The master modport is the controller's view; slave is the surrounding system's view.
interface snn_input_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              clr_rx_rdy;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data;
  logic [ADDR_W-1:0] core_addr;
  logic              core_start;
  logic              core_done;
  logic [3:0]        core_digit;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [3:0]        result;
  logic              result_vld;
  logic              busy;

  modport master (
    input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_busy,
    output clr_rx_rdy, ram_we, ram_addr, ram_data, core_start,
           tx_start, tx_data, result, result_vld, busy
  );

  modport slave (
    output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_busy,
    input  clr_rx_rdy, ram_we, ram_addr, ram_data, core_start,
           tx_start, tx_data, result, result_vld, busy
  );
endinterface

// File: rtl/snn_input_ctrl.sv
// Sequences one SNN inference: loads a packed binary image into the input RAM one pixel per
// cycle (rx_rdy to first write 1 cycle), runs the core, then reports the digit, waiting on tx_busy.
module snn_input_ctrl #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_W     = 10
) (
  input logic              clk,
  input logic              rst,
  snn_input_ctrl_if.master bus
);
  localparam int NUM_BYTES = NUM_PIXELS / 8;
  localparam int BC_W      = ADDR_W - 3;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    WAIT_BYTE = 3'd0,
    UNPACK    = 3'd1,
    START     = 3'd2,
    RUN       = 3'd3,
    WAIT_TX   = 3'd4,
    REPORT    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      sreg_q, sreg_d;
  logic [3:0]      result_q, result_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            clr_rx_rdy_q, clr_rx_rdy_d;
  logic            core_start_q, core_start_d;
  logic            tx_start_q, tx_start_d;
  logic            result_vld_q, result_vld_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sreg_d     = sreg_q;
    result_d   = result_q;

    case (state_q)
      WAIT_BYTE: begin
        if (bus.rx_rdy) begin
          sreg_d    = bus.rx_data;
          bit_cnt_d = 3'd0;
          state_d   = UNPACK;
        end
      end
      UNPACK: begin
        // Shifting right keeps the current pixel in sreg_q[0], so ram_data comes straight off a flop.
        sreg_d    = {1'b0, sreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = START;
          end else begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
            state_d    = WAIT_BYTE;
          end
        end
      end
      START: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.core_done) begin
          result_d = bus.core_digit;
          state_d  = bus.tx_busy ? WAIT_TX : REPORT;
        end
      end
      WAIT_TX: begin
        if (!bus.tx_busy) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        state_d = WAIT_BYTE;
      end
      default: begin
        state_d = WAIT_BYTE;
      end
    endcase

    // Pulse outputs are decoded from the next state so they line up with the state they belong to.
    clr_rx_rdy_d = (state_q == WAIT_BYTE) && bus.rx_rdy;
    core_start_d = (state_d == START);
    tx_start_d   = (state_d == REPORT);
    result_vld_d = (state_d == REPORT);
    tx_data_d    = {4'h0, result_d};
    busy_d       = (state_d != WAIT_BYTE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_BYTE;
      byte_cnt_q   <= '0;
      bit_cnt_q    <= 3'd0;
      sreg_q       <= 8'h00;
      result_q     <= 4'h0;
      tx_data_q    <= 8'h00;
      clr_rx_rdy_q <= 1'b0;
      core_start_q <= 1'b0;
      tx_start_q   <= 1'b0;
      result_vld_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sreg_q       <= sreg_d;
      result_q     <= result_d;
      tx_data_q    <= tx_data_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
      core_start_q <= core_start_d;
      tx_start_q   <= tx_start_d;
      result_vld_q <= result_vld_d;
      busy_q       <= busy_d;
    end
  end

  // The core owns the RAM address port only while it runs; otherwise it is the loader's.
  assign bus.ram_addr   = (state_q == RUN) ? bus.core_addr : {byte_cnt_q, bit_cnt_q};
  assign bus.ram_we     = (state_q == UNPACK);
  assign bus.ram_data   = sreg_q[0];

  assign bus.clr_rx_rdy = clr_rx_rdy_q;
  assign bus.core_start = core_start_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.result     = result_q;
  assign bus.result_vld = result_vld_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_snn_input_ctrl.sv
// Directed bench for snn_input_ctrl: byte unpacking, mid-load reset, full image load, core handoff
// and result reporting with and without transmitter backpressure.
module tb_snn_input_ctrl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  snn_input_ctrl_if #(.ADDR_W(10)) bus_if ();

  snn_input_ctrl #(.NUM_PIXELS(784), .ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  int   n_total   = 0;
  int   n_bad     = 0;
  int   start_cnt = 0;
  int   oob_cnt   = 0;
  logic mem [0:1023];

  // Input RAM model plus counters for start pulses and out-of-range writes.
  always @(posedge clk) begin
    if (bus_if.ram_we) begin
      mem[bus_if.ram_addr] = bus_if.ram_data;
      if (bus_if.ram_addr >= 10'd784) oob_cnt++;
    end
    if (bus_if.core_start) start_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [7:0] pat(input int k);
    return (k == 0) ? 8'h55 : 8'((k * 37 + 11) & 255);
  endfunction

  task automatic check_writes(input logic [7:0] b, input int base);
    for (int i = 0; i < 8; i++) begin
      chk("we", 32'(bus_if.ram_we), 32'd1);
      chk("waddr", 32'(bus_if.ram_addr), 32'(base + i));
      chk("wdata", 32'(bus_if.ram_data), 32'(b[i]));
      if (i == 1) chk("clr_pulse_len", 32'(bus_if.clr_rx_rdy), 32'd0);
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int base);
    bus_if.rx_rdy  = 1'b1;
    bus_if.rx_data = b;
    tick();
    chk("clr_ack", 32'(bus_if.clr_rx_rdy), 32'd1);
    bus_if.rx_rdy = 1'b0;
    check_writes(b, base);
  endtask

  initial begin
    int         ones;
    int         mis;
    logic [7:0] bb;

    for (int i = 0; i < 1024; i++) mem[i] = 1'b0;
    rst               = 1'b1;
    bus_if.rx_rdy     = 1'b0;
    bus_if.rx_data    = 8'h00;
    bus_if.core_addr  = 10'h000;
    bus_if.core_done  = 1'b0;
    bus_if.core_digit = 4'h0;
    bus_if.tx_busy    = 1'b0;
    repeat (3) tick();

    chk("rst_clr", 32'(bus_if.clr_rx_rdy), 32'd0);
    chk("rst_we", 32'(bus_if.ram_we), 32'd0);
    chk("rst_addr", 32'(bus_if.ram_addr), 32'd0);
    chk("rst_start", 32'(bus_if.core_start), 32'd0);
    chk("rst_tx_start", 32'(bus_if.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus_if.tx_data), 32'd0);
    chk("rst_result", 32'(bus_if.result), 32'd0);
    chk("rst_result_vld", 32'(bus_if.result_vld), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte, LSB-first unpack.
    send_byte(8'hA5, 0);
    chk("a5_busy_after", 32'(bus_if.busy), 32'd0);
    chk("a5_we_after", 32'(bus_if.ram_we), 32'd0);
    chk("a5_mem", {24'd0, mem[7], mem[6], mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]}, 32'hA5);

    // Reset held two cycles partway through a byte.
    bus_if.rx_rdy  = 1'b1;
    bus_if.rx_data = 8'h3C;
    tick();
    chk("mid_clr", 32'(bus_if.clr_rx_rdy), 32'd1);
    bus_if.rx_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mid_addr", 32'(bus_if.ram_addr), 32'(8 + i));
      tick();
    end
    rst = 1'b1;
    tick();
    tick();
    chk("mid_rst_we", 32'(bus_if.ram_we), 32'd0);
    chk("mid_rst_addr", 32'(bus_if.ram_addr), 32'd0);
    chk("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    chk("mid_rst_clr", 32'(bus_if.clr_rx_rdy), 32'd0);
    chk("mid_rst_result", 32'(bus_if.result), 32'd0);
    rst = 1'b0;
    tick();

    // Full image of ones; the first byte after reset must land at address 0.
    for (int k = 0; k < 98; k++) begin
      send_byte(8'hFF, 8 * k);
      if (k < 97) chk("img1_start_early", 32'(start_cnt), 32'd0);
    end
    chk("img1_start", 32'(bus_if.core_start), 32'd1);
    chk("img1_we_off", 32'(bus_if.ram_we), 32'd0);
    tick();
    chk("img1_start_len", 32'(bus_if.core_start), 32'd0);
    chk("img1_busy_run", 32'(bus_if.busy), 32'd1);
    ones = 0;
    for (int p = 0; p < 784; p++) if (mem[p] === 1'b1) ones++;
    chk("img1_ones", 32'(ones), 32'd784);
    chk("img1_oob", 32'(oob_cnt), 32'd0);
    chk("img1_start_cnt", 32'(start_cnt), 32'd1);

    // RUN: address pass-through and rx_rdy left pending.
    bus_if.rx_rdy  = 1'b1;
    bus_if.rx_data = 8'h55;
    for (int a = 1; a <= 4; a++) begin
      bus_if.core_addr = 10'(a);
      #1;
      chk("run_addr", 32'(bus_if.ram_addr), 32'(a));
      chk("run_we", 32'(bus_if.ram_we), 32'd0);
      chk("run_clr", 32'(bus_if.clr_rx_rdy), 32'd0);
      tick();
    end

    bus_if.core_done  = 1'b1;
    bus_if.core_digit = 4'd7;
    tick();
    bus_if.core_done  = 1'b0;
    bus_if.core_digit = 4'd0;
    chk("rep_tx_start", 32'(bus_if.tx_start), 32'd1);
    chk("rep_tx_data", 32'(bus_if.tx_data), 32'h07);
    chk("rep_result", 32'(bus_if.result), 32'd7);
    chk("rep_vld", 32'(bus_if.result_vld), 32'd1);
    chk("rep_clr", 32'(bus_if.clr_rx_rdy), 32'd0);
    tick();
    chk("rep_tx_start_len", 32'(bus_if.tx_start), 32'd0);
    chk("rep_vld_len", 32'(bus_if.result_vld), 32'd0);
    chk("rep_result_hold", 32'(bus_if.result), 32'd7);
    chk("rep_busy_after", 32'(bus_if.busy), 32'd0);
    chk("rep_clr_late", 32'(bus_if.clr_rx_rdy), 32'd0);
    tick();
    chk("post_rep_clr", 32'(bus_if.clr_rx_rdy), 32'd1);
    bus_if.rx_rdy = 1'b0;
    check_writes(8'h55, 0);

    // core_done while idle must not disturb the held result.
    bus_if.core_done  = 1'b1;
    bus_if.core_digit = 4'd9;
    tick();
    bus_if.core_done  = 1'b0;
    bus_if.core_digit = 4'd0;
    chk("idle_done_result", 32'(bus_if.result), 32'd7);
    chk("idle_done_busy", 32'(bus_if.busy), 32'd0);
    chk("idle_done_tx", 32'(bus_if.tx_start), 32'd0);

    // Second image with a varied pattern.
    for (int k = 1; k < 98; k++) send_byte(pat(k), 8 * k);
    chk("img2_start", 32'(bus_if.core_start), 32'd1);
    tick();
    chk("img2_start_cnt", 32'(start_cnt), 32'd2);
    mis = 0;
    for (int p = 0; p < 784; p++) begin
      bb = pat(p / 8);
      if (mem[p] !== bb[p % 8]) mis++;
    end
    chk("img2_mem_mis", 32'(mis), 32'd0);
    chk("img2_oob", 32'(oob_cnt), 32'd0);

    // Transmitter busy for five sampled edges.
    bus_if.tx_busy    = 1'b1;
    bus_if.core_done  = 1'b1;
    bus_if.core_digit = 4'd3;
    tick();
    bus_if.core_done  = 1'b0;
    bus_if.core_digit = 4'd0;
    for (int i = 0; i < 5; i++) begin
      chk("wtx_no_start", 32'(bus_if.tx_start), 32'd0);
      chk("wtx_result", 32'(bus_if.result), 32'd3);
      chk("wtx_busy", 32'(bus_if.busy), 32'd1);
      if (i < 4) tick();
    end
    bus_if.tx_busy = 1'b0;
    tick();
    chk("wtx_tx_start", 32'(bus_if.tx_start), 32'd1);
    chk("wtx_tx_data", 32'(bus_if.tx_data), 32'h03);
    chk("wtx_vld", 32'(bus_if.result_vld), 32'd1);
    tick();
    chk("wtx_tx_start_len", 32'(bus_if.tx_start), 32'd0);
    chk("wtx_result_hold", 32'(bus_if.result), 32'd3);
    chk("wtx_idle", 32'(bus_if.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
